// File: rtl/gm_fm_result_checker.sv
// gm_fm_result_checker
//   Compares golden against faulty multiplier products lane by lane, counts
//   accepted beats and mismatching lanes, remembers the first mismatching
//   beat index, and queues one record per mismatching beat for readout.
//
// Optional feature macro: RESCHK_DROP_ON_FULL_EN
//   undefined : the input stalls while the record FIFO is full; drop_count = 0.
//   defined   : the input never stalls on FIFO occupancy. A mismatching beat
//               that finds the FIFO full (and no pop that cycle) is still
//               counted, but its record is discarded and drop_count increments.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, total_beats    campaign start pulse and its beat count
//   in_valid/in_ready     beat handshake; golden/faulty carry LANES products
//   busy, done            RUN/DRAIN and DONE status
//   beat_count            beats accepted in this campaign
//   mismatch_count        mismatching lanes, saturating
//   first_mis_valid/_idx  first mismatching beat
//   rec_valid/rec_ready   record FIFO head handshake
//   rec_idx/mask/golden/faulty  head record contents (0 while empty)
//   drop_count            records discarded on a full FIFO
module gm_fm_result_checker #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 2,
  parameter int IDX_W      = 16,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        total_beats,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] golden,
  input  logic [LANES*DATA_W-1:0] faulty,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        beat_count,
  output logic [CNT_W-1:0]        mismatch_count,
  output logic                    first_mis_valid,
  output logic [IDX_W-1:0]        first_mis_idx,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [IDX_W-1:0]        rec_idx,
  output logic [LANES-1:0]        rec_mask,
  output logic [LANES*DATA_W-1:0] rec_golden,
  output logic [LANES*DATA_W-1:0] rec_faulty,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int PW     = LANES * DATA_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_FW = PTR_W + 1;
  localparam int REC_W  = IDX_W + LANES + 2 * PW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] total_q;
  logic [IDX_W-1:0] beat_count_q;
  logic [CNT_W-1:0] mismatch_count_q;
  logic             first_mis_valid_q;
  logic [IDX_W-1:0] first_mis_idx_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0] fifo_count_q;
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];

  logic [LANES-1:0] mask;
  logic             any_mis;
  logic             fifo_full;
  logic             accept, push, pop, start_ok;
  logic [CNT_W:0]   mis_add, mis_sum;
  logic [CNT_W-1:0] mis_next;
  logic [REC_W-1:0] head_word;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign mask[gi] = golden[gi*DATA_W +: DATA_W] != faulty[gi*DATA_W +: DATA_W];
  end

  assign any_mis   = |mask;
  assign fifo_full = (fifo_count_q == CNT_FW'(FIFO_DEPTH));
  assign rec_valid = (fifo_count_q != '0);
  assign pop       = rec_valid && rec_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // The beat_count/total compare only matters for total_beats == 0: it keeps
  // the single RUN cycle of an empty campaign from taking a stray beat.
`ifdef RESCHK_DROP_ON_FULL_EN
  logic [CNT_W-1:0] drop_count_q;
  logic             drop;
  assign in_ready   = (state_q == S_RUN) && (beat_count_q != total_q);
  // A same-cycle pop frees the slot, so the push still lands.
  assign push       = accept && any_mis && (!fifo_full || pop);
  assign drop       = accept && any_mis && fifo_full && !pop;
  assign drop_count = drop_count_q;

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      drop_count_q <= '0;
    end else if (drop && drop_count_q != '1) begin
      drop_count_q <= drop_count_q + CNT_W'(1);
    end
  end
`else
  assign in_ready   = (state_q == S_RUN) && (beat_count_q != total_q) && !fifo_full;
  assign push       = accept && any_mis;
  assign drop_count = '0;
`endif

  // Saturating add of the number of mismatching lanes in this beat.
  always_comb begin
    mis_add = '0;
    for (int i = 0; i < LANES; i++) begin
      mis_add = mis_add + (CNT_W+1)'(mask[i]);
    end
    mis_sum  = {1'b0, mismatch_count_q} + mis_add;
    mis_next = mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (beat_count_q == total_q) begin
          state_d = S_DRAIN;
        end else if (accept && (beat_count_q + IDX_W'(1) == total_q)) begin
          state_d = S_DRAIN;
        end
      end
      // An empty FIFO means rec_valid is low, so no pop can be pending.
      S_DRAIN: if (fifo_count_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      total_q           <= reset ? '0 : total_beats;
      beat_count_q      <= '0;
      mismatch_count_q  <= '0;
      first_mis_valid_q <= 1'b0;
      first_mis_idx_q   <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      fifo_count_q      <= '0;
    end else begin
      if (accept) begin
        beat_count_q     <= beat_count_q + IDX_W'(1);
        mismatch_count_q <= mis_next;
        if (any_mis && !first_mis_valid_q) begin
          first_mis_valid_q <= 1'b1;
          first_mis_idx_q   <= beat_count_q;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_FW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_FW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Record storage: no reset; entries are only visible once counted valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {beat_count_q, mask, golden, faulty};
  end

  // Head entry is never overwritten while it is held, so rec_* stay stable.
  assign head_word  = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign rec_idx    = head_word[REC_W-1 -: IDX_W];
  assign rec_mask   = head_word[2*PW +: LANES];
  assign rec_golden = head_word[PW +: PW];
  assign rec_faulty = head_word[0 +: PW];

  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign beat_count      = beat_count_q;
  assign mismatch_count  = mismatch_count_q;
  assign first_mis_valid = first_mis_valid_q;
  assign first_mis_idx   = first_mis_idx_q;

endmodule

// File: tb/tb_gm_fm_result_checker.sv
module tb_gm_fm_result_checker;
  localparam int DATA_W = 16;
  localparam int LANES  = 2;
  localparam int IDX_W  = 16;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 8;
  localparam int PW     = LANES * DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             start = 0, in_valid = 0, rec_ready = 0;
  logic [IDX_W-1:0] total_beats = '0;
  logic [PW-1:0]    golden = '0, faulty = '0;
  logic             in_ready, busy, done, first_mis_valid, rec_valid;
  logic [IDX_W-1:0] beat_count, first_mis_idx, rec_idx;
  logic [CNT_W-1:0] mismatch_count, drop_count;
  logic [LANES-1:0] rec_mask;
  logic [PW-1:0]    rec_golden, rec_faulty;

  gm_fm_result_checker #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W),
                         .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .total_beats(total_beats),
    .in_valid(in_valid), .in_ready(in_ready), .golden(golden), .faulty(faulty),
    .busy(busy), .done(done), .beat_count(beat_count),
    .mismatch_count(mismatch_count), .first_mis_valid(first_mis_valid),
    .first_mis_idx(first_mis_idx), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_mask(rec_mask), .rec_golden(rec_golden),
    .rec_faulty(rec_faulty), .drop_count(drop_count));

  // INT16 configuration instance
  logic        start16 = 0, in_valid16 = 0, rec_ready16 = 0;
  logic [15:0] total16 = '0;
  logic [31:0] golden16 = '0, faulty16 = '0;
  logic        in_ready16, busy16, done16, fmv16, rec_valid16;
  logic [15:0] beat_count16, fmi16, rec_idx16;
  logic [31:0] mis16, drop16, rec_golden16, rec_faulty16;
  logic [0:0]  rec_mask16;

  gm_fm_result_checker #(.DATA_W(32), .LANES(1), .IDX_W(16), .CNT_W(32),
                         .FIFO_DEPTH(4)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .total_beats(total16),
    .in_valid(in_valid16), .in_ready(in_ready16), .golden(golden16),
    .faulty(faulty16), .busy(busy16), .done(done16), .beat_count(beat_count16),
    .mismatch_count(mis16), .first_mis_valid(fmv16), .first_mis_idx(fmi16),
    .rec_valid(rec_valid16), .rec_ready(rec_ready16), .rec_idx(rec_idx16),
    .rec_mask(rec_mask16), .rec_golden(rec_golden16), .rec_faulty(rec_faulty16),
    .drop_count(drop16));

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LANES-1:0] mask;
    logic [PW-1:0]    g;
    logic [PW-1:0]    f;
  } rec_t;

  rec_t        exp_q[$];
  int unsigned exp_beats = 0, exp_mis = 0, exp_first_idx = 0, exp_drop = 0;
  bit          exp_first_v = 0;
  int          errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_beats = 0; exp_mis = 0; exp_first_idx = 0; exp_drop = 0; exp_first_v = 0;
  endtask

  // Monitor + reference model, on the falling edge: first retire a pop, then
  // account for the beat that the next rising edge will accept.
  always @(negedge clock) begin
    if (!reset) begin
      check("rec_valid", rec_valid, exp_q.size() != 0);
      if (rec_valid && rec_ready && exp_q.size() != 0) begin
        rec_t e;
        e = exp_q.pop_front();
        $display("pop  idx=%0d mask=%b", rec_idx, rec_mask);
        check("rec_idx", rec_idx, e.idx);
        check("rec_mask", rec_mask, e.mask);
        check("rec_golden", rec_golden, e.g);
        check("rec_faulty", rec_faulty, e.f);
      end
      if (in_valid && in_ready) begin
        logic [LANES-1:0] m;
        int unsigned pc;
        pc = 0;
        for (int l = 0; l < LANES; l++) begin
          m[l] = golden[l*DATA_W +: DATA_W] != faulty[l*DATA_W +: DATA_W];
          pc += m[l];
        end
        $display("beat idx=%0d mask=%b", exp_beats, m);
        if (m != 0) begin
          if (!exp_first_v) begin
            exp_first_v = 1;
            exp_first_idx = exp_beats;
          end
`ifdef RESCHK_DROP_ON_FULL_EN
          if (exp_q.size() >= DEPTH) exp_drop++;
          else exp_q.push_back('{IDX_W'(exp_beats), m, golden, faulty});
`else
          exp_q.push_back('{IDX_W'(exp_beats), m, golden, faulty});
`endif
        end
        exp_mis = (exp_mis + pc < exp_mis) ? 32'hFFFF_FFFF : exp_mis + pc;
        exp_beats++;
      end
    end
  end

  task automatic gen_beat(input int pmis, output logic [PW-1:0] g, output logic [PW-1:0] f);
    logic [DATA_W-1:0] x;
    g = PW'($urandom);
    f = g;
    for (int l = 0; l < LANES; l++) begin
      if (int'($urandom_range(99)) < pmis) begin
        x = DATA_W'($urandom_range(65535, 1));
        f[l*DATA_W +: DATA_W] = f[l*DATA_W +: DATA_W] ^ x;
      end
    end
  endtask

  task automatic do_start(input int tb);
    @(posedge clock); #1;
    model_clear();
    start = 1; total_beats = IDX_W'(tb);
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic check_final(input string name);
    check({name, "_beats"}, beat_count, exp_beats);
    check({name, "_mis"}, mismatch_count, exp_mis);
    check({name, "_fmv"}, first_mis_valid, exp_first_v);
    check({name, "_fmi"}, first_mis_idx, exp_first_idx);
    check({name, "_drop"}, drop_count, exp_drop);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_rec_valid"}, rec_valid, 0);
    check({name, "_beat_count"}, beat_count, 0);
    check({name, "_mis"}, mismatch_count, 0);
    check({name, "_fmv"}, first_mis_valid, 0);
    check({name, "_fmi"}, first_mis_idx, 0);
    check({name, "_rec_idx"}, rec_idx, 0);
    check({name, "_rec_mask"}, rec_mask, 0);
    check({name, "_rec_golden"}, rec_golden, 0);
    check({name, "_rec_faulty"}, rec_faulty, 0);
    check({name, "_drop"}, drop_count, 0);
  endtask

  task automatic run_random(input string name, input int total, input int pmis,
                            input int pvalid, input int pready, input int budget);
    int n = 0;
    do_start(total);
    while (!done && n < budget) begin
      gen_beat(pmis, golden, faulty);
      in_valid  = int'($urandom_range(99)) < pvalid;
      rec_ready = int'($urandom_range(99)) < pready;
      @(posedge clock); #1;
      n++;
    end
    in_valid = 0; rec_ready = 1;
    check({name, "_done"}, done, 1);
    check_final(name);
  endtask

  initial begin
    logic [31:0] g16;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("rst0");
    reset = 0;

    // Clean run: no record may ever appear
    run_random("clean", 4, 0, 100, 100, 100);
    check("clean_beat_count", beat_count, 4);
    check("clean_mis", mismatch_count, 0);

    // Single mismatch on beat 1, lane 0
    do_start(3);
    rec_ready = 0;
    for (int b = 0; b < 3; b++) begin
      gen_beat(0, golden, faulty);
      if (b == 1) begin golden = 32'h1234_0010; faulty = 32'h1234_0011; end
      in_valid = 1;
      @(posedge clock); #1;
    end
    in_valid = 0;
    check("one_rec_idx", rec_idx, 1);
    check("one_rec_mask", rec_mask, 2'b01);
    rec_ready = 1;
    wait_done("one", 20);
    check("one_mis", mismatch_count, 1);
    check("one_fmi", first_mis_idx, 1);
    check_final("one");

    // Backpressure / drop with 10 mismatching beats and no consumer
    do_start(10);
    rec_ready = 0;
    for (int c = 0; c < 20; c++) begin
      gen_beat(100, golden, faulty);
      in_valid = 1;
      @(posedge clock); #1;
    end
`ifdef RESCHK_DROP_ON_FULL_EN
    check("bp_beats", beat_count, 10);
    check("bp_drop", drop_count, 2);
`else
    check("bp_beats", beat_count, 8);
    check("bp_in_ready", in_ready, 0);
`endif
    rec_ready = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      gen_beat(100, golden, faulty);
      @(posedge clock); #1;
    end
    in_valid = 0;
    check("bp_done", done, 1);
    check("bp_total", beat_count, 10);
    check_final("bp");

    // Both lanes mismatch on beat 0; start mid-RUN must be ignored
    do_start(3);
    rec_ready = 1;
    gen_beat(100, golden, faulty);
    in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0; start = 1; total_beats = 16'd1;
    @(posedge clock); #1;
    start = 0;
    check("midstart_busy", busy, 1);
    check("midstart_beats", beat_count, 1);
    check("midstart_mis", mismatch_count, 2);
    for (int b = 0; b < 2; b++) begin
      gen_beat(0, golden, faulty);
      in_valid = 1;
      @(posedge clock); #1;
    end
    in_valid = 0;
    wait_done("midstart", 20);
    check("midstart_total", beat_count, 3);
    check_final("midstart");

    // Reset mid-campaign after 2 beats, then an empty campaign
    do_start(5);
    rec_ready = 0;
    for (int b = 0; b < 2; b++) begin
      gen_beat(100, golden, faulty);
      in_valid = 1;
      @(posedge clock); #1;
    end
    in_valid = 0; reset = 1;
    @(posedge clock); #1;
    reset = 0;
    model_clear();
    check_reset_values("rst_mid");
    rec_ready = 1;
    do_start(0);
    check("empty_c1_done", done, 0);
    check("empty_c1_busy", busy, 1);
    @(posedge clock); #1;
    check("empty_c2_done", done, 0);
    @(posedge clock); #1;
    check("empty_c3_done", done, 1);
    check_final("empty");

    // Randomized campaigns
    for (int r = 0; r < 6; r++) begin
      run_random("rand", int'($urandom_range(12, 1)), 30, 70, 60, 500);
    end

    // INT16 configuration: top-bit flip
    @(posedge clock); #1;
    start16 = 1; total16 = 16'd1;
    @(posedge clock); #1;
    start16 = 0;
    g16 = $urandom;
    golden16 = g16; faulty16 = g16 ^ 32'h8000_0000; in_valid16 = 1;
    @(posedge clock); #1;
    in_valid16 = 0;
    check("i16_rec_valid", rec_valid16, 1);
    check("i16_rec_mask", rec_mask16, 1);
    check("i16_rec_idx", rec_idx16, 0);
    check("i16_rec_faulty", rec_faulty16, g16 ^ 32'h8000_0000);
    check("i16_mis", mis16, 1);
    rec_ready16 = 1;
    for (int c = 0; c < 10 && !done16; c++) begin
      @(posedge clock); #1;
    end
    check("i16_done", done16, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
